key_schedule_seq: RTL and testbench
===================================

# key_schedule_seq

Sequential, runtime-mode AES key expansion engine. It generates one 32-bit schedule word per cycle for AES-128, AES-192 or AES-256, selected per key, and streams 128-bit round keys through a valid/ready handshake. It succeeds the single-round combinational expander and feeds the round datapath. Optionally it keeps every round key for random-access reads in reverse order during decryption.

## Interface
- `ROUNDS_MAX`, default 14: round-key storage depth minus 1; only used when the configuration macro is defined.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to expand `key_in`; accepted only in IDLE.
- `mode`  in  2  key size: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved (treated as AES-128). Sampled with `start`.
- `key_in`  in  256  cipher key, left-aligned. AES-128 uses [255:128]; AES-192 uses [255:64].
- `busy`  out  1  high from the acceptance edge until the final round key is consumed.
- `rk_valid`  out  1  `rk_data` holds a round key.
- `rk_ready`  in  1  consumer accepts the round key.
- `rk_data`  out  128  round key {w[4j], w[4j+1], w[4j+2], w[4j+3]}; w[4j] is in [127:96].
- `rk_idx`  out  4  round-key index j, 0..Nr.
- `done`  out  1  one-cycle pulse on the handshake of round key Nr.
- `rd_idx`  in  4  storage read index; present only with the macro.
- `rd_data`  out  128  stored round key; present only with the macro.

## Operation
- Nk and Nr per mode: 4/10, 6/12, 8/14. Total words T = 4(Nr+1), giving 44, 52 or 60.
- States:
  - IDLE: `start` is accepted; go to GEN, with i=0, k=0 (i mod Nk), rcon=0x01, and the key and Nk registered.
  - GEN: one word w[i] is produced per non-stalled cycle; go to DRAIN after w[T-1].
  - DRAIN: wait for the last handshake, then return to IDLE.
- Word rule:
  - For i < Nk, w[i] = key word i.
  - Otherwise t = w[i-1], and:
    - if k==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon = xtime(rcon) after use;
    - else if Nk==8 and k==4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
- History: an 8-word shift register, where win[0] = w[i-1] and w[i-Nk] = win[Nk-1].
- Assembly: when i mod 4 == 3, {w[i-3..i]} loads `rk_data` and `rk_idx` = i>>2, and `rk_valid` sets.
- Handshake: `rk_valid && rk_ready` consumes the key. `rk_data` is stable while `rk_valid && !rk_ready`. `rk_valid` never drops without a handshake.
- Backpressure: GEN stalls, with all state held, only on a cycle that would complete a round key (i mod 4 == 3) while the output is full and not being consumed. A simultaneous consume and complete proceeds without a bubble.
- `start` in GEN or DRAIN is ignored. Changing `key_in` or `mode` after acceptance has no effect.

## Timing
- Reset values: `busy`=0, `rk_valid`=0, `rk_data`=0, `rk_idx`=0, `done`=0, `rd_data`=0. State = IDLE, rcon = 0x01.
- Start accepted at edge E0. Words are produced at E1..ET. `rk_valid` is first high after E4.
- With `rk_ready` held high, round key j is presented after edge E(4j+4). `done` is high in the cycle of the final handshake. `busy` falls at the edge after that handshake.
- `rst_n` low mid-expansion clears everything immediately; no partial key is presented after release.
- There is no combinational path from `rk_ready` to `rk_valid` or `rk_data`.

## Configuration
- `KEY_SCHED_STORE_EN` defined:
  - A register file of ROUNDS_MAX+1 × 128 is written with every round key as it loads into `rk_data`.
  - `rd_data` is registered and equals entry `rd_idx` one cycle later.
  - Contents persist until the next accepted `start`, which overwrites entries in order.
  - `rd_idx` > Nr returns 0.
- Undefined: no storage, the `rd_idx`/`rd_data` ports are absent, and the block is streaming only.

## Structure
- Shared `aes_pkg` holds:
  - the mode encoding constants (MODE_128/192/256);
  - functions `nk_of(mode)` and `nr_of(mode)`;
  - the `xtime` function;
  - the 32-bit `word_t` type.
- Sub-module `key_word_gen` (combinational) takes w[i-1], w[i-Nk], k, Nk and rcon and returns w[i]. It instantiates the existing S-box four times.

## Test plan
- **AES-128**, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, `rk_ready`=1:
  - rk 1 = a0fafe17 88542cb1 23a33939 2a6c7605;
  - rk 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6;
  - `done` 44 cycles after acceptance.
- **AES-192**, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - rk 12 = e98ba06f 448c773c 8ecc7204 01002202;
  - 13 handshakes.
- **AES-256**, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - rk 14 = fe4890d1 e6188d0b 046df344 706c631e;
  - the k==4 SubWord path is exercised.
- **Random `rk_ready` throttling** on the AES-128 vector:
  - identical key sequence;
  - `rk_data` stable during every stall;
  - no index skipped.
- **`start` during GEN** is ignored. **`rst_n` pulsed at word 20** leaves all outputs 0. A new `start` then yields the correct rk 0.
- **With `KEY_SCHED_STORE_EN`**, after AES-128 `done`:
  - `rd_idx`=10 gives d014f9a8… one cycle later;
  - `rd_idx`=12 gives 0.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule types, mode encoding and GF(2^8) helpers
package aes_pkg;

   localparam logic [1:0] MODE_128 = 2'b00;
   localparam logic [1:0] MODE_192 = 2'b01;
   localparam logic [1:0] MODE_256 = 2'b10;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_DRAIN} ks_state_e;

   // Reserved mode 2'b11 falls back to AES-128.
   function automatic logic [3:0] nk_of(input logic [1:0] mode);
      case (mode)
         MODE_192: return 4'd6;
         MODE_256: return 4'd8;
         default:  return 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] mode);
      case (mode)
         MODE_192: return 4'd12;
         MODE_256: return 4'd14;
         default:  return 4'd10;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - AES forward S-box: GF(2^8) inverse followed by the affine map
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      r = 8'h01;
      for (int n = 7; n >= 0; n--) begin
         r = gf_mul(r, r);
         if (n != 0) r = gf_mul(r, x);
      end
      return r;
   endfunction

   logic [7:0] inv;

   always_comb begin
      inv   = gf_inv(in_i);
      out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/key_word_gen.sv
// rtl/key_word_gen.sv - combinational next-word rule of the AES key expansion
module key_word_gen
   import aes_pkg::*;
(
   input  word_t      w_prev_i,
   input  word_t      w_nk_i,
   input  logic [2:0] k_i,
   input  logic [3:0] nk_i,
   input  logic [7:0] rcon_i,
   output word_t      w_o
);

   word_t sb_in;
   word_t sb_out;
   word_t t;

   assign sb_in = (k_i == 3'd0) ? {w_prev_i[23:0], w_prev_i[31:24]} : w_prev_i;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .in_i  (sb_in[8*b +: 8]),
         .out_o (sb_out[8*b +: 8])
      );
   end

   always_comb begin
      t = w_prev_i;
      if (k_i == 3'd0) begin
         t = sb_out ^ {rcon_i, 24'h000000};
      end else if (nk_i == 4'd8 && k_i == 3'd4) begin
         t = sb_out;
      end
      w_o = w_nk_i ^ t;
   end

endmodule

// File: rtl/key_schedule_seq.sv
// rtl/key_schedule_seq.sv - one-word-per-cycle AES-128/192/256 key expander; KEY_SCHED_STORE_EN adds round-key storage
module key_schedule_seq
   import aes_pkg::*;
`ifdef KEY_SCHED_STORE_EN
#(
   parameter int ROUNDS_MAX = 14
)
`endif
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_idx,
   output logic         done
`ifdef KEY_SCHED_STORE_EN
   ,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_data
`endif
);

   ks_state_e    state_q;
   logic [5:0]   i_q;
   logic [2:0]   k_q, k_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [3:0]   nk_q, nr_q;
   logic [255:0] key_q;
   word_t        win_q [8];
   logic [127:0] rk_data_q;
   logic [3:0]   rk_idx_q;
   logic         rk_valid_q, busy_q;

   word_t        key_w [8];
   word_t        w_gen, w_cur;
   logic [2:0]   nkm1;
   logic         in_key, rk_done_w, stall, hs, last_w, advance, load;
   logic [127:0] rk_next;

   // Nk=8 wraps to 0 in three bits, so nkm1 is always the w[i-Nk] tap.
   assign nkm1 = 3'(nk_q - 4'd1);

   key_word_gen u_gen (
      .w_prev_i (win_q[0]),
      .w_nk_i   (win_q[nkm1]),
      .k_i      (k_q),
      .nk_i     (nk_q),
      .rcon_i   (rcon_q),
      .w_o      (w_gen)
   );

   always_comb begin
      for (int n = 0; n < 8; n++) key_w[n] = key_q[255 - 32*n -: 32];
      in_key    = (i_q < {2'b00, nk_q});
      w_cur     = in_key ? key_w[i_q[2:0]] : w_gen;
      rk_next   = {win_q[2], win_q[1], win_q[0], w_cur};
      rk_done_w = (i_q[1:0] == 2'b11);
      hs        = rk_valid_q && rk_ready;
      // Only a word that completes a round key can be blocked by a full output.
      stall     = rk_done_w && rk_valid_q && !rk_ready;
      last_w    = (i_q == {nr_q, 2'b11});
      advance   = (state_q == ST_GEN) && !stall;
      load      = advance && rk_done_w;
      k_d       = ({1'b0, k_q} == nk_q - 4'd1) ? 3'd0 : k_q + 3'd1;
      rcon_d    = (!in_key && k_q == 3'd0) ? xtime(rcon_q) : rcon_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         i_q        <= '0;
         k_q        <= '0;
         rcon_q     <= 8'h01;
         nk_q       <= 4'd4;
         nr_q       <= 4'd10;
         key_q      <= '0;
         for (int n = 0; n < 8; n++) win_q[n] <= '0;
         rk_data_q  <= '0;
         rk_idx_q   <= '0;
         rk_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_GEN;
                  i_q     <= '0;
                  k_q     <= '0;
                  rcon_q  <= 8'h01;
                  key_q   <= key_in;
                  nk_q    <= nk_of(mode);
                  nr_q    <= nr_of(mode);
                  busy_q  <= 1'b1;
               end
            end
            ST_GEN: begin
               if (advance) begin
                  for (int n = 7; n > 0; n--) win_q[n] <= win_q[n-1];
                  win_q[0] <= w_cur;
                  i_q      <= i_q + 6'd1;
                  k_q      <= k_d;
                  rcon_q   <= rcon_d;
                  if (last_w) state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (hs && rk_idx_q == nr_q) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         if (load) begin
            rk_valid_q <= 1'b1;
            rk_data_q  <= rk_next;
            rk_idx_q   <= i_q[5:2];
         end else if (hs) begin
            rk_valid_q <= 1'b0;
         end
      end
   end

   assign busy     = busy_q;
   assign rk_valid = rk_valid_q;
   assign rk_data  = rk_data_q;
   assign rk_idx   = rk_idx_q;
   assign done     = hs && (rk_idx_q == nr_q);

`ifdef KEY_SCHED_STORE_EN
   logic [127:0] store_q [ROUNDS_MAX+1];
   logic [127:0] rd_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n <= ROUNDS_MAX; n++) store_q[n] <= '0;
         rd_data_q <= '0;
      end else begin
         if (load && int'(i_q[5:2]) <= ROUNDS_MAX) store_q[i_q[5:2]] <= rk_next;
         if (rd_idx <= nr_q && int'(rd_idx) <= ROUNDS_MAX) rd_data_q <= store_q[rd_idx];
         else rd_data_q <= '0;
      end
   end

   assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_key_schedule_seq.sv
// tb/tb_key_schedule_seq.sv - directed table-driven bench for key_schedule_seq
module tb_key_schedule_seq;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                    128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                    64'ha5a5a5a5a5a5a5a5};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   localparam logic [127:0] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RK128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   mode = 2'b00;
   logic [255:0] key_in = '0;
   logic         rk_ready = 1'b1;
   logic         busy, rk_valid, done;
   logic [127:0] rk_data;
   logic [3:0]   rk_idx;
`ifdef KEY_SCHED_STORE_EN
   logic [3:0]   rd_idx = 4'd0;
   logic [127:0] rd_data;
`endif

   always #5 clk = ~clk;

   key_schedule_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .key_in   (key_in),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_data  (rk_data),
      .rk_idx   (rk_idx),
      .done     (done)
`ifdef KEY_SCHED_STORE_EN
      ,
      .rd_idx   (rd_idx),
      .rd_data  (rd_data)
`endif
   );

   typedef struct {
      logic [1:0]   mode;
      logic [255:0] key;
      int           idx;
      logic [127:0] exp;
   } vec_t;

   int           total = 0;
   int           bad = 0;
   logic [127:0] rk_got [16];
   int           hs_cnt, done_c, first_v;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int nr_model(input logic [1:0] m);
      case (m)
         2'b01:   return 12;
         2'b10:   return 14;
         default: return 10;
      endcase
   endfunction

   task automatic run_expand(input logic [1:0] m, input logic [255:0] key,
                             input bit throttle, input int glitch_at);
      int           c, viol, idx_err, done_err, nr;
      bit           fin, prev_stall;
      logic [127:0] prev_data;
      logic [3:0]   prev_idx;
      c = 0; viol = 0; idx_err = 0; done_err = 0; fin = 0; prev_stall = 0;
      prev_data = '0; prev_idx = '0;
      nr = nr_model(m);
      hs_cnt = 0; done_c = -1; first_v = -1;
      for (int n = 0; n < 16; n++) rk_got[n] = '0;
      @(posedge clk); #1;
      mode = m; key_in = key; start = 1'b1; rk_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; key_in = ~key; mode = ~m;
      chk("busy_after_start", busy, 1);
      while (!fin && c < 400) begin
         @(posedge clk); #1;
         c++;
         if (c == glitch_at) begin
            start = 1'b1; mode = 2'b10; key_in = {8{32'h0f0f0f0f}};
         end else begin
            start = 1'b0;
         end
         if (prev_stall && (!rk_valid || rk_data !== prev_data || rk_idx !== prev_idx)) viol++;
         if (rk_valid && first_v < 0) first_v = c;
         rk_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (rk_valid && rk_ready) begin
            if (int'(rk_idx) != hs_cnt) idx_err++;
            rk_got[rk_idx] = rk_data;
            if (done !== (int'(rk_idx) == nr)) done_err++;
            if (done) begin
               done_c = c;
               fin = 1;
            end
            hs_cnt++;
         end else if (done !== 1'b0) begin
            done_err++;
         end
         prev_stall = rk_valid && !rk_ready;
         prev_data  = rk_data;
         prev_idx   = rk_idx;
      end
      start = 1'b0;
      chk("done_seen", fin, 1);
      chk("stall_stable", viol, 0);
      chk("idx_seq", idx_err, 0);
      chk("done_pulse", done_err, 0);
      chk("hs_count", hs_cnt, nr + 1);
      @(posedge clk); #1;
      chk("busy_fall", busy, 0);
      rk_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tab [10];
      int   cnt;
      tab[0] = '{2'b00, K128, 0,  RK128_0};
      tab[1] = '{2'b00, K128, 1,  RK128_1};
      tab[2] = '{2'b00, K128, 2,  RK128_2};
      tab[3] = '{2'b00, K128, 10, RK128_10};
      tab[4] = '{2'b01, K192, 1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
      tab[5] = '{2'b01, K192, 12, 128'he98ba06f448c773c8ecc720401002202};
      tab[6] = '{2'b10, K256, 1,  128'h1f352c073b6108d72d9810a30914dff4};
      tab[7] = '{2'b10, K256, 3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a};
      tab[8] = '{2'b10, K256, 14, 128'hfe4890d1e6188d0b046df344706c631e};
      tab[9] = '{2'b11, K128, 10, RK128_10};

      #2;
      chk("rst_busy", busy, 0);
      chk("rst_valid", rk_valid, 0);
      chk("rst_data", rk_data, 0);
      chk("rst_idx", rk_idx, 0);
      chk("rst_done", done, 0);
`ifdef KEY_SCHED_STORE_EN
      chk("rst_rd_data", rd_data, 0);
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int v = 0; v < 10; v++) begin
         run_expand(tab[v].mode, tab[v].key, 0, -1);
         chk($sformatf("vec%0d_rk%0d", v, tab[v].idx), rk_got[tab[v].idx], tab[v].exp);
         chk($sformatf("vec%0d_done_cycle", v), done_c, 4 * (nr_model(tab[v].mode) + 1));
         chk($sformatf("vec%0d_first_valid", v), first_v, 4);
      end

      run_expand(2'b00, K128, 1, -1);
      chk("thr_rk0", rk_got[0], RK128_0);
      chk("thr_rk1", rk_got[1], RK128_1);
      chk("thr_rk2", rk_got[2], RK128_2);
      chk("thr_rk10", rk_got[10], RK128_10);

      run_expand(2'b00, K128, 0, 10);
      chk("glitch_rk10", rk_got[10], RK128_10);
      chk("glitch_done_cycle", done_c, 44);

`ifdef KEY_SCHED_STORE_EN
      rd_idx = 4'd10;
      @(posedge clk); #1;
      chk("store_rd10", rd_data, RK128_10);
      rd_idx = 4'd12;
      @(posedge clk); #1;
      chk("store_rd12", rd_data, 0);
`endif

      @(posedge clk); #1;
      mode = 2'b00; key_in = K128; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", rk_valid, 0);
      chk("midrst_data", rk_data, 0);
      chk("midrst_idx", rk_idx, 0);
      chk("midrst_done", done, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      cnt = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (rk_valid || busy) cnt++;
      end
      chk("no_partial_after_rst", cnt, 0);
      run_expand(2'b00, K128, 0, -1);
      chk("post_rst_rk0", rk_got[0], RK128_0);
      chk("post_rst_rk10", rk_got[10], RK128_10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
